// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter (open-drain ps2c/ps2d)
// Define PS2_TX_ACK_EN to add the device-ACK state and the ack_err output.
module ps2_tx #(
  parameter int unsigned RTS_CYCLES = 8191
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick
`ifdef PS2_TX_ACK_EN
  ,
  output logic       ack_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP,
    S_ACK
  } state_t;

  localparam logic [12:0] RTS_LOAD = 13'(RTS_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  filter_q, filter_d;
  logic        f_ps2c_q, f_ps2c_d;
  logic [12:0] c_q, c_d;
  logic [3:0]  n_q, n_d;
  logic [8:0]  b_q, b_d;
  logic        done_q, done_d;
  logic        drv_c_q, drv_c_d;
  logic        drv_d_q, drv_d_d;
  logic        fall_edge;
`ifdef PS2_TX_ACK_EN
  logic        ack_err_q, ack_err_d;
`endif

  // Glitch filter: the filtered clock only moves on 8 agreeing samples.
  always_comb begin
    filter_d = {ps2c, filter_q[7:1]};
    if (filter_q == 8'hff) begin
      f_ps2c_d = 1'b1;
    end else if (filter_q == 8'h00) begin
      f_ps2c_d = 1'b0;
    end else begin
      f_ps2c_d = f_ps2c_q;
    end
    fall_edge = f_ps2c_q & ~f_ps2c_d;
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef PS2_TX_ACK_EN
    ack_err_d = ack_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (wr_ps2) begin
          b_d     = {~^din, din};
          c_d     = RTS_LOAD;
          state_d = S_RTS;
        end
      end
      S_RTS: begin
        if (c_q == 13'd0) begin
          state_d = S_START;
        end else begin
          c_d = c_q - 13'd1;
        end
      end
      S_START: begin
        if (fall_edge) begin
          n_d     = 4'd8;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          b_d = {1'b0, b_q[8:1]};
          if (n_q == 4'd0) begin
            state_d = S_STOP;
          end else begin
            n_d = n_q - 4'd1;
          end
        end
      end
      S_STOP: begin
        if (fall_edge) begin
`ifdef PS2_TX_ACK_EN
          state_d = S_ACK;
`else
          done_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PS2_TX_ACK_EN
      S_ACK: begin
        if (fall_edge) begin
          ack_err_d = ps2d;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Line drives follow the next state so they register with it.
    drv_c_d = (state_d == S_RTS);
    drv_d_d = (state_d == S_START) | ((state_d == S_DATA) & ~b_d[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      filter_q <= 8'h00;
      f_ps2c_q <= 1'b0;
      c_q      <= 13'd0;
      n_q      <= 4'd0;
      b_q      <= 9'd0;
      done_q   <= 1'b0;
      drv_c_q  <= 1'b0;
      drv_d_q  <= 1'b0;
`ifdef PS2_TX_ACK_EN
      ack_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
      c_q      <= c_d;
      n_q      <= n_d;
      b_q      <= b_d;
      done_q   <= done_d;
      drv_c_q  <= drv_c_d;
      drv_d_q  <= drv_d_d;
`ifdef PS2_TX_ACK_EN
      ack_err_q <= ack_err_d;
`endif
    end
  end

  assign ps2c         = drv_c_q ? 1'b0 : 1'bz;
  assign ps2d         = drv_d_q ? 1'b0 : 1'bz;
  assign tx_idle      = (state_q == S_IDLE);
  assign tx_done_tick = done_q;
`ifdef PS2_TX_ACK_EN
  assign ack_err      = ack_err_q;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - randomized bench for ps2_tx with a device model and frame-level reference
module tb_ps2_tx;

  localparam int RTS      = 16;
  localparam int FILT_LAT = 9;
  localparam int BIG      = 1000000000;
`ifdef PS2_TX_ACK_EN
  localparam int EDGES = 12;
`else
  localparam int EDGES = 11;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       dev_c = 1'b0;
  logic       dev_d = 1'b0;
  wire        ps2c;
  wire        ps2d;
`ifdef PS2_TX_ACK_EN
  logic       ack_err;
`endif

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c ? 1'b0 : 1'bz;
  assign ps2d = dev_d ? 1'b0 : 1'bz;

  ps2_tx #(.RTS_CYCLES(RTS)) dut (
    .clk(clk),
    .reset(reset),
    .wr_ps2(wr_ps2),
    .din(din),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick)
`ifdef PS2_TX_ACK_EN
    ,
    .ack_err(ack_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_from = BIG;
  int done_at = BIG;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  function automatic bit model_idle(input int c);
    return !(c >= busy_from && c < done_at);
  endfunction

  // Per-cycle compare against the frame-level model.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      chk("tx_idle", tx_idle, model_idle(cyc));
      chk("tx_done_tick", tx_done_tick, (cyc == done_at));
      chk("ps2c", ps2c, !(dev_c || (busy_from != BIG && cyc >= busy_from && cyc <= busy_from + RTS)));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_write(input logic [7:0] d);
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    if (model_idle(cyc)) begin
      busy_from = cyc + 1;
      done_at = BIG;
    end
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  task automatic device_frame(input int nedges, input int glitch_at, input bit ack_pull,
                              output logic [10:0] bits);
    int half;
    bits = '0;
    for (int i = 0; i < 200 && cyc <= busy_from + RTS; i++) @(negedge clk);
    chk("rts release wait", (cyc > busy_from + RTS), 1);
    repeat (20) @(negedge clk);
    bits[0] = ps2d;
    for (int k = 1; k <= nedges; k++) begin
      half = $urandom_range(20, 30);
      if (k == glitch_at) begin
        dev_c = 1'b1;
        repeat (5) @(negedge clk);
        dev_c = 1'b0;
        repeat (20) @(negedge clk);
      end
      @(negedge clk);
      dev_c = 1'b1;
      if (k == 12) dev_d = ack_pull;
      if (k == EDGES) done_at = cyc + FILT_LAT;
      repeat (half) @(negedge clk);
      if (k <= 10) bits[k] = ps2d;
      dev_c = 1'b0;
      dev_d = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int glitch_at, input bit ack_pull,
                           output logic [10:0] bits);
    send_write(d);
    device_frame(EDGES, glitch_at, ack_pull, bits);
    chk("frame bits", bits, model_frame(d));
`ifdef PS2_TX_ACK_EN
    @(negedge clk);
    chk("ack_err", ack_err, !ack_pull);
`endif
  endtask

  logic [10:0] bits;
  logic [10:0] bits_bg;

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset ps2d", ps2d, 1);
`ifdef PS2_TX_ACK_EN
      chk("reset ack_err", ack_err, 0);
`endif
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(8'hF4, 0, 1'b1, bits);
    chk("F4 literal frame", bits, 11'h5E8);
    run_frame(8'h00, 0, 1'b1, bits);
    chk("parity 00", bits[9], 1);
    run_frame(8'hFF, 0, 1'b1, bits);
    chk("parity FF", bits[9], 1);
    run_frame(8'h01, 0, 1'b1, bits);
    chk("parity 01", bits[9], 0);

    // Write during the data phase must be ignored.
    fork
      begin
        send_write(8'hF4);
        device_frame(EDGES, 0, 1'b1, bits_bg);
      end
      begin
        repeat (150) @(negedge clk);
        send_write(8'hAA);
      end
    join
    chk("ignored write frame", bits_bg, 11'h5E8);

    // Short clock glitch in the data phase.
    run_frame(8'h5A, 5, 1'b1, bits);

    // Reset after the 4th data edge.
    send_write(8'h3C);
    device_frame(5, 0, 1'b1, bits);
    chk("mid frame busy", tx_idle, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    busy_from = BIG;
    done_at = BIG;
    #1;
    chk("reset ps2c released", ps2c, 1);
    chk("reset ps2d released", ps2d, 1);
    chk("reset tx_idle", tx_idle, 1);
    chk("reset tx_done_tick", tx_done_tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(8'hC3, 0, 1'b1, bits);

`ifdef PS2_TX_ACK_EN
    run_frame(8'h12, 0, 1'b0, bits);
    run_frame(8'h34, 0, 1'b1, bits);
`endif

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 15)) @(negedge clk);
      run_frame(8'($urandom), (r % 3 == 0) ? int'($urandom_range(2, 10)) : 0,
                1'($urandom_range(0, 1)), bits);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
